// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter that pops four upstream FIFOs into one downstream stage.
// Two-stage pipeline: the grant registers the source, then the next edge captures its read data.
module fifo_rr_arbiter #(
    parameter int BUS_SIZE = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          empty,
    input  logic [BUS_SIZE-1:0] data_in0,
    input  logic [BUS_SIZE-1:0] data_in1,
    input  logic [BUS_SIZE-1:0] data_in2,
    input  logic [BUS_SIZE-1:0] data_in3,
    input  logic                valid_in0,
    input  logic                valid_in1,
    input  logic                valid_in2,
    input  logic                valid_in3,
    input  logic                pause_out,
    output logic [3:0]          pop,
    output logic                push_out,
    output logic [BUS_SIZE-1:0] data_out,
    output logic [1:0]          sel_out,
    output logic [7:0]          fwd_count,
    output logic [7:0]          drop_count,
    output logic                busy
);

    localparam int NUM_IN = 4;

    logic [1:0]          prio_q, prio_d;
    logic                s1_v_q, s1_v_d;
    logic [1:0]          s1_sel_q, s1_sel_d;
    logic                push_out_q, push_out_d;
    logic [BUS_SIZE-1:0] data_out_q, data_out_d;
    logic [1:0]          sel_out_q, sel_out_d;
    logic [7:0]          fwd_count_q, fwd_count_d;
    logic [7:0]          drop_count_q, drop_count_d;

    logic                grant_v;
    logic [1:0]          grant_idx;
    logic [1:0]          scan_idx;
    logic [BUS_SIZE-1:0] sel_data;
    logic                sel_valid;

    // Scan starts at prio and wraps; the first non-empty FIFO wins.
    always_comb begin
        grant_v   = 1'b0;
        grant_idx = 2'd0;
        scan_idx  = 2'd0;
        pop       = 4'b0000;
        if (!reset && !pause_out) begin
            for (int k = 0; k < NUM_IN; k++) begin
                scan_idx = prio_q + 2'(k);
                if (!grant_v && !empty[scan_idx]) begin
                    grant_v   = 1'b1;
                    grant_idx = scan_idx;
                end
            end
        end
        if (grant_v) begin
            pop[grant_idx] = 1'b1;
        end
    end

    // Read data from the FIFO popped last cycle.
    always_comb begin
        sel_data  = data_in0;
        sel_valid = valid_in0;
        case (s1_sel_q)
            2'd0: begin sel_data = data_in0; sel_valid = valid_in0; end
            2'd1: begin sel_data = data_in1; sel_valid = valid_in1; end
            2'd2: begin sel_data = data_in2; sel_valid = valid_in2; end
            default: begin sel_data = data_in3; sel_valid = valid_in3; end
        endcase
    end

    always_comb begin
        prio_d       = prio_q;
        s1_v_d       = grant_v;
        s1_sel_d     = s1_sel_q;
        push_out_d   = 1'b0;
        data_out_d   = data_out_q;
        sel_out_d    = sel_out_q;
        fwd_count_d  = fwd_count_q;
        drop_count_d = drop_count_q;

        if (grant_v) begin
            prio_d   = grant_idx + 2'd1;
            s1_sel_d = grant_idx;
        end

        if (s1_v_q) begin
            data_out_d = sel_data;
            sel_out_d  = s1_sel_q;
            push_out_d = sel_valid;
            // Tag-0 words are consumed from the FIFO but never forwarded.
            if (sel_valid) begin
                fwd_count_d = fwd_count_q + 8'd1;
            end else begin
                drop_count_d = drop_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q       <= 2'd0;
            s1_v_q       <= 1'b0;
            s1_sel_q     <= 2'd0;
            push_out_q   <= 1'b0;
            data_out_q   <= '0;
            sel_out_q    <= 2'd0;
            fwd_count_q  <= 8'd0;
            drop_count_q <= 8'd0;
        end else begin
            prio_q       <= prio_d;
            s1_v_q       <= s1_v_d;
            s1_sel_q     <= s1_sel_d;
            push_out_q   <= push_out_d;
            data_out_q   <= data_out_d;
            sel_out_q    <= sel_out_d;
            fwd_count_q  <= fwd_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign push_out   = push_out_q;
    assign data_out   = data_out_q;
    assign sel_out    = sel_out_q;
    assign fwd_count  = fwd_count_q;
    assign drop_count = drop_count_q;
    assign busy       = s1_v_q | push_out_q;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter: four queue-based FIFO models feed the DUT,
// and every expected value below is worked out by hand from the cycle numbering.
module tb_fifo_rr_arbiter;

    localparam int W = 5;

    logic         clk;
    logic         reset;
    logic [3:0]   empty;
    logic [W-1:0] din0, din1, din2, din3;
    logic         vin0, vin1, vin2, vin3;
    logic         pause_out;
    logic [3:0]   pop;
    logic         push_out;
    logic [W-1:0] data_out;
    logic [1:0]   sel_out;
    logic [7:0]   fwd_count;
    logic [7:0]   drop_count;
    logic         busy;

    logic [W:0] q0[$];
    logic [W:0] q1[$];
    logic [W:0] q2[$];
    logic [W:0] q3[$];

    int n_assert;
    int n_fail;
    int npush;

    fifo_rr_arbiter #(.BUS_SIZE(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .empty      (empty),
        .data_in0   (din0),
        .data_in1   (din1),
        .data_in2   (din2),
        .data_in3   (din3),
        .valid_in0  (vin0),
        .valid_in1  (vin1),
        .valid_in2  (vin2),
        .valid_in3  (vin3),
        .pause_out  (pause_out),
        .pop        (pop),
        .push_out   (push_out),
        .data_out   (data_out),
        .sel_out    (sel_out),
        .fwd_count  (fwd_count),
        .drop_count (drop_count),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic upd_empty();
        empty = {q3.size() == 0, q2.size() == 0, q1.size() == 0, q0.size() == 0};
    endtask

    task automatic load(input int i, input logic v, input logic [W-1:0] d);
        case (i)
            0: q0.push_back({v, d});
            1: q1.push_back({v, d});
            2: q2.push_back({v, d});
            default: q3.push_back({v, d});
        endcase
        upd_empty();
    endtask

    task automatic take(input int i);
        case (i)
            0: if (q0.size() > 0) {vin0, din0} = q0.pop_front();
            1: if (q1.size() > 0) {vin1, din1} = q1.pop_front();
            2: if (q2.size() > 0) {vin2, din2} = q2.pop_front();
            default: if (q3.size() > 0) {vin3, din3} = q3.pop_front();
        endcase
    endtask

    // Sample pop before the edge, then let the FIFO models respond after it.
    task automatic adv();
        logic [3:0] p;
        logic [3:0] e;
        #1;
        p = pop;
        e = empty;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (p[i]) begin
                chk("pop_to_nonempty", 32'(e[i]), 32'h0);
                take(i);
            end
        end
        upd_empty();
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        pause_out = 1'b0;
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
        upd_empty();
        adv();
        adv();
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        npush     = 0;
        reset     = 1'b1;
        pause_out = 1'b0;
        {din0, din1, din2, din3} = '0;
        {vin0, vin1, vin2, vin3} = '0;
        upd_empty();

        // Reset state, then a single word from FIFO 2
        do_reset();
        load(2, 1'b1, 5'h15);
        settle();
        chk("rst_pop", 32'(pop), 32'h0);
        chk("rst_push", 32'(push_out), 32'h0);
        chk("rst_data", 32'(data_out), 32'h0);
        chk("rst_sel", 32'(sel_out), 32'h0);
        chk("rst_fwd", 32'(fwd_count), 32'h0);
        chk("rst_drop", 32'(drop_count), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        settle();
        chk("one_pop_c1", 32'(pop), 32'h4);
        adv(); settle();
        chk("one_pop_c2", 32'(pop), 32'h0);
        chk("one_push_c2", 32'(push_out), 32'h0);
        chk("one_busy_c2", 32'(busy), 32'h1);
        adv(); settle();
        chk("one_push_c3", 32'(push_out), 32'h1);
        chk("one_data_c3", 32'(data_out), 32'h15);
        chk("one_sel_c3", 32'(sel_out), 32'h2);
        chk("one_fwd_c3", 32'(fwd_count), 32'h1);
        adv(); settle();
        chk("one_push_c4", 32'(push_out), 32'h0);
        chk("one_busy_c4", 32'(busy), 32'h0);

        // Four FIFOs x 3 words: strict rotation, back-to-back pushes
        do_reset();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 3; k++)
                load(i, 1'b1, W'(i * 8 + k));
        reset = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            settle();
            if (c <= 12) chk("rr_pop", 32'(pop), 32'(1 << ((c - 1) % 4)));
            else         chk("rr_pop_idle", 32'(pop), 32'h0);
            if (c >= 3) begin
                chk("rr_push", 32'(push_out), 32'h1);
                chk("rr_data", 32'(data_out), 32'(((c - 3) % 4) * 8 + (c - 3) / 4));
                chk("rr_sel", 32'(sel_out), 32'((c - 3) % 4));
            end else begin
                chk("rr_push_early", 32'(push_out), 32'h0);
            end
            adv();
        end
        settle();
        chk("rr_push_end", 32'(push_out), 32'h0);
        chk("rr_fwd", 32'(fwd_count), 32'd12);

        // Stream FIFO 1, pause at cycle 4, resume at cycle 7 with prio kept
        do_reset();
        for (int k = 0; k < 6; k++) load(1, 1'b1, W'(5'h10 + k));
        reset = 1'b0;
        settle(); chk("ps_pop_c1", 32'(pop), 32'h2); adv();
        settle(); chk("ps_pop_c2", 32'(pop), 32'h2); adv();
        settle(); chk("ps_pop_c3", 32'(pop), 32'h2);
        chk("ps_data_c3", 32'(data_out), 32'h10); adv();
        pause_out = 1'b1;
        settle();
        chk("ps_pop_c4", 32'(pop), 32'h0);
        chk("ps_push_c4", 32'(push_out), 32'h1);
        chk("ps_data_c4", 32'(data_out), 32'h11);
        adv();
        load(3, 1'b1, 5'h03);
        load(0, 1'b1, 5'h00);
        settle();
        chk("ps_pop_c5", 32'(pop), 32'h0);
        chk("ps_push_c5", 32'(push_out), 32'h1);
        chk("ps_data_c5", 32'(data_out), 32'h12);
        adv(); settle();
        chk("ps_pop_c6", 32'(pop), 32'h0);
        chk("ps_push_c6", 32'(push_out), 32'h0);
        chk("ps_busy_c6", 32'(busy), 32'h0);
        chk("ps_fwd_c6", 32'(fwd_count), 32'h3);
        adv();
        pause_out = 1'b0;
        settle(); chk("ps_pop_c7", 32'(pop), 32'h8); adv();
        settle(); chk("ps_pop_c8", 32'(pop), 32'h1); adv();
        settle(); chk("ps_pop_c9", 32'(pop), 32'h2);

        // Tag-0 word dropped, tag-1 word forwarded
        do_reset();
        load(0, 1'b0, 5'h0A);
        load(0, 1'b1, 5'h0B);
        reset = 1'b0;
        settle(); chk("dr_pop_c1", 32'(pop), 32'h1); adv();
        settle(); chk("dr_pop_c2", 32'(pop), 32'h1); adv();
        settle();
        chk("dr_push_c3", 32'(push_out), 32'h0);
        chk("dr_drop_c3", 32'(drop_count), 32'h1);
        chk("dr_fwd_c3", 32'(fwd_count), 32'h0);
        adv(); settle();
        chk("dr_push_c4", 32'(push_out), 32'h1);
        chk("dr_data_c4", 32'(data_out), 32'h0B);
        chk("dr_sel_c4", 32'(sel_out), 32'h0);
        chk("dr_fwd_c4", 32'(fwd_count), 32'h1);
        chk("dr_drop_c4", 32'(drop_count), 32'h1);
        adv(); settle();
        chk("dr_push_c5", 32'(push_out), 32'h0);

        // Reset one cycle after a pop discards the word; scan restarts at 0
        do_reset();
        load(1, 1'b1, 5'h07);
        load(2, 1'b1, 5'h08);
        reset = 1'b0;
        settle(); chk("mr_pop_c1", 32'(pop), 32'h2); adv();
        reset = 1'b1;
        load(0, 1'b1, 5'h09);
        settle(); chk("mr_pop_rst", 32'(pop), 32'h0); adv();
        reset = 1'b0;
        settle();
        chk("mr_push_c3", 32'(push_out), 32'h0);
        chk("mr_fwd_c3", 32'(fwd_count), 32'h0);
        chk("mr_drop_c3", 32'(drop_count), 32'h0);
        chk("mr_busy_c3", 32'(busy), 32'h0);
        chk("mr_pop_c3", 32'(pop), 32'h1);
        adv(); settle();
        chk("mr_push_c4", 32'(push_out), 32'h0);
        adv(); settle();
        chk("mr_push_c5", 32'(push_out), 32'h1);
        chk("mr_data_c5", 32'(data_out), 32'h09);
        chk("mr_fwd_c5", 32'(fwd_count), 32'h1);

        // fwd_count wraps 255 -> 0
        do_reset();
        for (int k = 0; k < 256; k++) load(0, 1'b1, W'(k));
        reset = 1'b0;
        for (int c = 1; c <= 258; c++) begin
            settle();
            if (push_out) npush++;
            if (c == 257) chk("wr_fwd_255", 32'(fwd_count), 32'd255);
            if (c == 258) chk("wr_fwd_0", 32'(fwd_count), 32'd0);
            adv();
        end
        chk("wr_npush", 32'(npush), 32'd256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
